// File: rtl/block_stack_pkg.sv
// block_stack_pkg: shared types, default widths and helpers for the block-stacking game stages.
//   GRID_W  : number of grid columns (bit 0 = leftmost)
//   CNT_W   : width of the speed divider / speed_count
//   NB_W    : width of block counts (num_blocks, landed_count)
//   state_t : row mover FSM states
//   dir_t   : horizontal sweep direction
package block_stack_pkg;
    localparam int GRID_W = 8;
    localparam int CNT_W  = 26;
    localparam int NB_W   = 4;
    typedef enum logic [2:0] {IDLE, LOAD, MOVE, LAND, RESULT} state_t;
    typedef enum logic {DIR_LEFT, DIR_RIGHT} dir_t;
    function automatic logic [NB_W-1:0] popcount(input logic [GRID_W-1:0] v);
        logic [NB_W-1:0] n;
        n = '0;
        for (int i = 0; i < GRID_W; i++) n = n + NB_W'(v[i]);
        return n;
    endfunction
endpackage

// File: rtl/move_divider.sv
// move_divider: counts 0..spd-1 while enabled and pulses tick on the last count.
//   clk, resetn : clock, asynchronous active-low reset
//   clear       : synchronous return of the count to 0
//   enable      : advance the count this cycle (tick is suppressed when low)
//   spd         : cycles per tick (must be >= 1)
//   tick        : one-cycle pulse when the count wraps
module move_divider #(
    parameter int CNT_W = 26
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] spd,
    output logic             tick
);
    logic [CNT_W-1:0] cnt;
    assign tick = enable && (cnt == spd - 1'b1);
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) cnt <= '0;
        else if (clear) cnt <= '0;
        else if (enable) cnt <= tick ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/block_row_mover.sv
// block_row_mover: sweeps a row of blocks across the grid and lands it on the row below.
//   clk, resetn  : clock, asynchronous active-low reset
//   go           : start a new row (accepted only when idle)
//   drop         : player drop pulse (accepted only while moving)
//   speed_count  : cycles per column step, latched on go (0 treated as 1)
//   num_blocks   : row width, latched on go (clamped to 1..GRID_W)
//   prev_row     : landed mask of the row below, sampled when landing
//   row_out      : current moving-row mask (0 when idle)
//   landed_row   : surviving blocks after landing, held until the next go
//   landed_count : number of surviving blocks
//   move_tick    : pulse on every position step
//   busy         : high whenever not idle
//   next_signal  : pulse when at least one block survived
//   fail         : pulse when no block survived
module block_row_mover
    import block_stack_pkg::*;
#(
    parameter int GRID_W = block_stack_pkg::GRID_W,
    parameter int CNT_W  = block_stack_pkg::CNT_W,
    parameter int NB_W   = block_stack_pkg::NB_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              go,
    input  logic              drop,
    input  logic [CNT_W-1:0]  speed_count,
    input  logic [NB_W-1:0]   num_blocks,
    input  logic [GRID_W-1:0] prev_row,
    output logic [GRID_W-1:0] row_out,
    output logic [GRID_W-1:0] landed_row,
    output logic [NB_W-1:0]   landed_count,
    output logic              move_tick,
    output logic              busy,
    output logic              next_signal,
    output logic              fail
);
    localparam int PW = $clog2(GRID_W);
    state_t            state;
    dir_t              dir;
    logic [PW-1:0]     pos;
    logic [CNT_W-1:0]  spd;
    logic [NB_W-1:0]   w;
    logic [PW:0]       reach;
    logic [GRID_W-1:0] mask;
    logic              can_right;
    // reach is one bit wider so pos+w == GRID_W does not wrap to 0
    assign reach       = {1'b0, pos} + (PW+1)'(w);
    assign can_right   = reach < (PW+1)'(GRID_W);
    assign mask        = ~({GRID_W{1'b1}} << w);
    assign row_out     = (state == IDLE) ? '0 : mask << pos;
    assign busy        = state != IDLE;
    assign next_signal = (state == RESULT) && (landed_count != '0);
    assign fail        = (state == RESULT) && (landed_count == '0);
    // a drop wins over a step falling on the same cycle, so the divider is held
    move_divider #(.CNT_W(CNT_W)) u_div (
        .clk    (clk),
        .resetn (resetn),
        .clear  (state != MOVE),
        .enable ((state == MOVE) && !drop),
        .spd    (spd),
        .tick   (move_tick)
    );
    // parameters are captured on the go edge so row_out is already valid in LOAD
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            dir          <= DIR_RIGHT;
            pos          <= '0;
            spd          <= CNT_W'(1);
            w            <= NB_W'(1);
            landed_row   <= '0;
            landed_count <= '0;
        end else begin
            case (state)
                IDLE: if (go) begin
                    state        <= LOAD;
                    spd          <= (speed_count == '0) ? CNT_W'(1) : speed_count;
                    w            <= (num_blocks == '0) ? NB_W'(1) :
                                    (num_blocks > NB_W'(GRID_W)) ? NB_W'(GRID_W) : num_blocks;
                    pos          <= '0;
                    dir          <= DIR_RIGHT;
                    landed_row   <= '0;
                    landed_count <= '0;
                end
                LOAD: state <= MOVE;
                MOVE: begin
                    if (drop) state <= LAND;
                    else if (move_tick) begin
                        if (dir == DIR_RIGHT) begin
                            if (can_right) pos <= pos + 1'b1;
                            else begin
                                dir <= DIR_LEFT;
                                if (pos != '0) pos <= pos - 1'b1;
                            end
                        end else begin
                            if (pos != '0) pos <= pos - 1'b1;
                            else begin
                                dir <= DIR_RIGHT;
                                if (can_right) pos <= pos + 1'b1;
                            end
                        end
                    end
                end
                LAND: begin
                    landed_row   <= row_out & prev_row;
                    landed_count <= popcount(row_out & prev_row);
                    state        <= RESULT;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_block_row_mover.sv
// tb_block_row_mover: scoreboard bench for block_row_mover against a closed-form bounce model.
module tb_block_row_mover;
    logic        clk = 0;
    logic        resetn = 0;
    logic        go = 0;
    logic        drop = 0;
    logic [25:0] speed_count = 0;
    logic [3:0]  num_blocks = 0;
    logic [7:0]  prev_row = 0;
    logic [7:0]  row_out, landed_row;
    logic [3:0]  landed_count;
    logic        move_tick, busy, next_signal, fail;

    block_row_mover dut (
        .clk(clk), .resetn(resetn), .go(go), .drop(drop),
        .speed_count(speed_count), .num_blocks(num_blocks), .prev_row(prev_row),
        .row_out(row_out), .landed_row(landed_row), .landed_count(landed_count),
        .move_tick(move_tick), .busy(busy), .next_signal(next_signal), .fail(fail)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] row;
        logic       tick;
        logic       nxt;
        logic       fl;
        logic [7:0] lrow;
        logic [3:0] lcnt;
    } item_t;

    item_t      q[$];
    int         n_chk = 0;
    int         n_fail = 0;
    bit         mon_en = 0;
    logic [7:0] hold_row = 0;
    logic [3:0] hold_cnt = 0;

    task automatic chk(input string nm, input int act, input int exp_v);
        n_chk++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
        end
    endtask

    // row position after k steps: a triangle wave over 0..8-w
    function automatic int bounce_pos(input int k, input int w);
        int r, m;
        r = 8 - w;
        if (r == 0) return 0;
        m = k % (2 * r);
        return (m <= r) ? m : 2 * r - m;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            if (busy) begin
                if (q.size() == 0) chk("busy_unexpected", 1, 0);
                else begin
                    item_t e;
                    e = q.pop_front();
                    chk("row_out", row_out, e.row);
                    chk("move_tick", move_tick, e.tick);
                    chk("next_signal", next_signal, e.nxt);
                    chk("fail", fail, e.fl);
                    chk("landed_row", landed_row, e.lrow);
                    chk("landed_count", landed_count, e.lcnt);
                    if (e.nxt || e.fl) begin
                        hold_row = e.lrow;
                        hold_cnt = e.lcnt;
                    end
                end
            end else begin
                chk("busy_missing", q.size(), 0);
                chk("idle_row_out", row_out, 0);
                chk("idle_pulses", {move_tick, next_signal, fail}, 0);
                chk("hold_landed_row", landed_row, hold_row);
                chk("hold_landed_count", landed_count, hold_cnt);
            end
        end
    end

    task automatic run_row(input int spd_in, input int nb, input logic [7:0] prev, input int d, input bit gd);
        int s, w, p;
        logic [7:0] m, lr;
        s = (spd_in == 0) ? 1 : spd_in;
        w = (nb == 0) ? 1 : ((nb > 8) ? 8 : nb);
        m = 8'((1 << w) - 1);
        @(posedge clk); #1;
        go = 1; drop = gd; speed_count = 26'(spd_in); num_blocks = 4'(nb);
        @(posedge clk); #1;
        go = 0; drop = 0;
        speed_count = 26'($urandom); num_blocks = 4'($urandom); prev_row = 8'($urandom);
        q.push_back('{row: m, tick: 0, nxt: 0, fl: 0, lrow: 0, lcnt: 0});
        for (int j = 0; j <= d; j++) begin
            p = bounce_pos(j / s, w);
            q.push_back('{row: m << p, tick: (j != d) && ((j + 1) % s == 0), nxt: 0, fl: 0, lrow: 0, lcnt: 0});
        end
        p = bounce_pos(d / s, w);
        lr = (m << p) & prev;
        q.push_back('{row: m << p, tick: 0, nxt: 0, fl: 0, lrow: 0, lcnt: 0});
        q.push_back('{row: m << p, tick: 0, nxt: lr != 0, fl: lr == 0, lrow: lr, lcnt: 4'($countones(lr))});
        for (int j = 0; j <= d; j++) begin
            @(posedge clk); #1;
            go = (j != d) && ($urandom_range(0, 5) == 0);
            drop = (j == d);
        end
        @(posedge clk); #1;
        drop = 0; go = 0; prev_row = prev;
        @(posedge clk); #1;
        prev_row = 8'($urandom); drop = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        drop = 0;
        repeat ($urandom_range(0, 2)) @(posedge clk);
    endtask

    initial begin
        #1;
        chk("reset_row_out", row_out, 0);
        chk("reset_busy", busy, 0);
        chk("reset_landed", {landed_row, landed_count}, 0);
        chk("reset_pulses", {move_tick, next_signal, fail}, 0);
        #13 resetn = 1;
        mon_en = 1;
        run_row(2, 3, 8'hFF, 30, 0);
        run_row(1, 2, 8'b0000_0110, 2, 0);
        run_row(1, 1, 8'b0000_0001, 7, 0);
        run_row(3, 4, 8'b1111_0000, 2, 0);
        run_row(1, 0, 8'b0000_0001, 5, 1);
        run_row(2, 12, 8'b1010_0101, 9, 0);
        run_row(0, 3, 8'b0011_1000, 4, 0);
        for (int i = 0; i < 40; i++)
            run_row($urandom_range(0, 4), $urandom_range(0, 15), 8'($urandom), $urandom_range(0, 40), 1'($urandom_range(0, 1)));
        mon_en = 0;
        @(posedge clk); #1;
        go = 1; speed_count = 1; num_blocks = 3;
        @(posedge clk); #1;
        go = 0;
        repeat (4) @(posedge clk);
        #2;
        chk("pre_reset_row", row_out, 8'b0011_1000);
        resetn = 0;
        #1;
        chk("async_row_out", row_out, 0);
        chk("async_busy", busy, 0);
        chk("async_pos", int'(dut.pos), 0);
        #3 resetn = 1;
        q.delete();
        hold_row = 0;
        hold_cnt = 0;
        @(posedge clk); #1;
        mon_en = 1;
        run_row(1, 3, 8'hFF, 3, 0);
        repeat (2) @(posedge clk);
        chk("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
